// File: rtl/riscv_fetch_queue.sv
// RISC-V instruction prefetch queue.
// Issues sequential fetches, buffers responses, handles redirects.
module riscv_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [31:0]     mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            exception
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

   logic [XLEN-1:0] q_pc    [DEPTH];
   logic [31:0]     q_instr [DEPTH];

   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW:0]     count;
   logic [XLEN-1:0] fetch_pc;
   logic            squash;

   logic            ack;
   logic            push;
   logic            pop;
   logic            issue;
   logic            bypass;
   logic [PW+1:0]   used;
   logic [PW-1:0]   rd_n;
   logic [PW:0]     count_n;
   logic [XLEN-1:0] fetch_pc_n;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;

   // Next-state decode: handshakes, issue reservation and head selection.
   always_comb begin
      ack        = mem_req & mem_ack;
      push       = ack & ~squash & ~redirect;
      pop        = out_valid & out_ready & ~redirect;
      fetch_pc_n = fetch_pc;
      if (redirect)
         fetch_pc_n = redirect_pc;
      else if (push)
         fetch_pc_n = fetch_pc + XLEN'(4);
      // The in-flight request is counted so its response always has a slot.
      used  = {1'b0, count} + (PW+2)'(mem_req);
      issue = ~stall & ~exception & ~redirect
            & (used < DEPTH_W) & (~mem_req | mem_ack);
      rd_n    = pop ? rd_ptr + PW'(1) : rd_ptr;
      count_n = count + (PW+1)'(push) - (PW+1)'(pop);
      // If the queue is empty after the pop, the new head is the pushed entry.
      bypass     = push & (count == (PW+1)'(pop));
      head_pc    = bypass ? mem_addr  : q_pc[rd_n];
      head_instr = bypass ? mem_rdata : q_instr[rd_n];
   end

   // Fetch side: request register, fetch PC, squash and exception flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_addr  <= RESET_PC;
         fetch_pc  <= RESET_PC;
         squash    <= 1'b0;
         exception <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_n;
         if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc_n;
         end else if (ack) begin
            mem_req <= 1'b0;
         end
         if (redirect)
            squash <= mem_req & ~mem_ack;
         else if (ack)
            squash <= 1'b0;
         if (redirect)
            exception <= |redirect_pc[1:0];
      end
   end

   // Queue bookkeeping and registered head outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
      end else if (redirect) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         rd_ptr    <= rd_n;
         wr_ptr    <= wr_ptr + PW'(push);
         count     <= count_n;
         out_valid <= (count_n != '0);
         if (count_n != '0) begin
            out_pc    <= head_pc;
            out_instr <= head_instr;
         end
      end
   end

   // Entry storage; no reset needed since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= mem_addr;
         q_instr[wr_ptr] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue.
// Two instances: default reset PC and a wrapping reset PC.
module tb_riscv_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, out_ready;
   logic [31:0] redirect_pc;
   logic        mem_req, mem_ack, out_valid, exception;
   logic [31:0] mem_addr, mem_rdata, out_pc, out_instr;

   logic        rst_b;
   logic        mem_req_b, mem_ack_b, out_valid_b, exception_b;
   logic [31:0] mem_addr_b, mem_rdata_b, out_pc_b, out_instr_b;

   int checks = 0;
   int errors = 0;
   int delay  = 0;
   int wcnt   = 0;
   int ack_cnt = 0;
   int a0;

   always #5 clk = ~clk;

   riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .exception(exception)
   );

   riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst_b), .stall(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
      .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .out_valid(out_valid_b),
      .out_ready(1'b1), .out_pc(out_pc_b), .out_instr(out_instr_b),
      .exception(exception_b)
   );

   // Memory models: mem[addr] = addr + 100, optional wait states on u_dut.
   assign mem_ack     = mem_req && (wcnt >= delay);
   assign mem_rdata   = mem_addr + 32'd100;
   assign mem_ack_b   = mem_req_b;
   assign mem_rdata_b = mem_addr_b + 32'd100;

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (mem_req && mem_ack)  ack_cnt <= ack_cnt + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst_b = 1'b1; stall = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; out_ready = 1'b1;
      tick(2);
      chk("rst_req",    mem_req,    0);
      chk("rst_addr",   mem_addr,   0);
      chk("rst_valid",  out_valid,  0);
      chk("rst_pc",     out_pc,     0);
      chk("rst_instr",  out_instr,  0);
      chk("rst_exc",    exception,  0);
      chk("rstb_addr",  mem_addr_b, 32'hFFFF_FFF8);
      chk("rstb_req",   mem_req_b,  0);

      // Streaming with zero-wait memory
      rst = 1'b0;
      tick(1);
      chk("s_req1",   mem_req,   1);
      chk("s_addr1",  mem_addr,  0);
      chk("s_valid1", out_valid, 0);
      tick(1);
      chk("s_valid2", out_valid, 1);
      chk("s_pc0",    out_pc,    0);
      chk("s_in0",    out_instr, 100);
      chk("s_addr2",  mem_addr,  4);
      tick(1);
      chk("s_pc4",    out_pc,    4);
      chk("s_in4",    out_instr, 104);
      tick(1);
      chk("s_pc8",    out_pc,    8);
      chk("s_in8",    out_instr, 108);

      // Fill with consumer blocked, then drain
      out_ready = 1'b0;
      do_reset();
      a0 = ack_cnt;
      tick(5);
      chk("f_req_off", mem_req, 0);
      tick(3);
      chk("f_req_hold", mem_req, 0);
      chk("f_acks",     ack_cnt - a0, 4);
      chk("f_addr",     mem_addr, 12);
      chk("f_head",     out_pc, 0);
      out_ready = 1'b1;
      tick(1);
      chk("f_pc4",  out_pc,  4);
      chk("f_req1", mem_req, 0);
      tick(1);
      chk("f_pc8",  out_pc,   8);
      chk("f_req2", mem_req,  1);
      chk("f_a16",  mem_addr, 16);
      tick(1);
      chk("f_pc12", out_pc,    12);
      chk("f_in12", out_instr, 112);
      tick(1);
      chk("f_pc16", out_pc,    16);
      chk("f_in16", out_instr, 116);

      // Stall while draining
      out_ready = 1'b0;
      do_reset();
      tick(5);
      stall = 1'b1; out_ready = 1'b1;
      tick(1);
      chk("st_pc4",  out_pc, 4);
      tick(1);
      chk("st_pc8",  out_pc, 8);
      chk("st_req",  mem_req, 0);
      tick(1);
      chk("st_pc12", out_pc, 12);
      tick(1);
      chk("st_empty", out_valid, 0);
      chk("st_hold",  out_pc, 12);
      tick(1);
      chk("st_req5", mem_req, 0);
      stall = 1'b0;
      tick(1);
      chk("st_resume", mem_req, 1);
      chk("st_a16",    mem_addr, 16);
      tick(1);
      chk("st_pc16",   out_pc, 16);

      // Redirect with a slow request in flight
      do_reset();
      tick(3);
      chk("r_addr8", mem_addr, 8);
      chk("r_pc4",   out_pc, 4);
      delay = 3;
      redirect = 1'b1; redirect_pc = 32'h40;
      tick(1);
      redirect = 1'b0;
      chk("r_req",   mem_req, 1);
      chk("r_hold",  mem_addr, 8);
      chk("r_flush", out_valid, 0);
      tick(2);
      chk("r_hold2", mem_addr, 8);
      chk("r_req2",  mem_req, 1);
      chk("r_empty", out_valid, 0);
      tick(1);
      chk("r_new",   mem_addr, 32'h40);
      chk("r_drop",  out_valid, 0);
      delay = 0;
      tick(1);
      chk("r_valid", out_valid, 1);
      chk("r_pc40",  out_pc, 32'h40);
      chk("r_in40",  out_instr, 32'hA4);

      // Misaligned redirect, then aligned recovery
      redirect = 1'b1; redirect_pc = 32'h42;
      tick(1);
      redirect = 1'b0;
      chk("x_exc",   exception, 1);
      chk("x_req",   mem_req, 0);
      chk("x_valid", out_valid, 0);
      tick(2);
      chk("x_req2",  mem_req, 0);
      chk("x_exc2",  exception, 1);
      redirect = 1'b1; redirect_pc = 32'h80;
      tick(1);
      redirect = 1'b0;
      chk("x_clr",   exception, 0);
      tick(1);
      chk("x_req3",  mem_req, 1);
      chk("x_a80",   mem_addr, 32'h80);
      tick(1);
      chk("x_pc80",  out_pc, 32'h80);
      chk("x_in80",  out_instr, 32'hE4);

      // Address wrap and mid-stream reset on the second instance
      rst_b = 1'b0;
      tick(1);
      chk("w_req",  mem_req_b, 1);
      chk("w_a",    mem_addr_b, 32'hFFFF_FFF8);
      tick(1);
      chk("w_pc0",  out_pc_b, 32'hFFFF_FFF8);
      chk("w_in0",  out_instr_b, 32'h5C);
      tick(1);
      chk("w_pc1",  out_pc_b, 32'hFFFF_FFFC);
      chk("w_in1",  out_instr_b, 32'h60);
      tick(1);
      chk("w_pc2",  out_pc_b, 32'h0);
      chk("w_in2",  out_instr_b, 32'h64);
      rst_b = 1'b1;
      tick(1);
      chk("w_rvld", out_valid_b, 0);
      chk("w_rreq", mem_req_b, 0);
      chk("w_raddr", mem_addr_b, 32'hFFFF_FFF8);
      chk("w_rpc",  out_pc_b, 0);
      rst_b = 1'b0;
      tick(1);
      chk("w_req2", mem_req_b, 1);
      chk("w_a2",   mem_addr_b, 32'hFFFF_FFF8);
      tick(1);
      chk("w_pc3",  out_pc_b, 32'hFFFF_FFF8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
